// File: rtl/cve2_ibus_arb_pkg.sv
// Shared types and limits for the instruction-bus arbiter.
package cve2_ibus_arb_pkg;

    // Arbiter FSM: free arbitration, or ownership frozen on one requester.
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        HOLD_F = 2'd1,
        HOLD_A = 2'd2
    } ibus_arb_state_e;

    // Identity of a bus owner, stored per outstanding transaction.
    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_A = 1'b1
    } ibus_owner_e;

    // Upper bound on granted-but-unanswered transactions.
    localparam int unsigned IBusMaxOutstandingMax = 32'd8;

endpackage

// File: rtl/cve2_ibus_arb_chk.sv
// Protocol checker for the instruction-bus arbiter. Compiled only when
// CVE2_IBUS_ARB_ASSERT_EN is defined.
`ifdef CVE2_IBUS_ARB_ASSERT_EN
module cve2_ibus_arb_chk
    import cve2_ibus_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 32'd2
) (
    input logic            clk_i,
    input logic            rst_i,
    input ibus_arb_state_e state_i,
    input logic            f_req_i,
    input logic            a_req_i,
    input logic            instr_rvalid_i,
    input logic            queue_empty_i
);

    if ((MaxOutstanding < 32'd1) || (MaxOutstanding > IBusMaxOutstandingMax)) begin : g_bad_depth
        $error("cve2_ibus_arb_chk: MaxOutstanding out of range");
    end

    // A requester must keep its request up until it is granted.
    a_hold_f_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_i == HOLD_F) |-> f_req_i);
    a_hold_a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_i == HOLD_A) |-> a_req_i);

    // A response with nothing outstanding is dropped by the arbiter.
    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> !queue_empty_i);

endmodule
`endif

// File: rtl/cve2_ibus_owner_fifo.sv
// In-order FIFO of 1-bit owner IDs, one entry per outstanding bus transaction.
// Pointers wrap modulo MaxOutstanding so non-power-of-two depths work.
module cve2_ibus_owner_fifo
    import cve2_ibus_arb_pkg::*;
#(
    parameter int unsigned  MaxOutstanding = 32'd2,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 32'd1),
    localparam int unsigned PtrW           = (MaxOutstanding > 32'd1) ? $clog2(MaxOutstanding) : 32'd1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  ibus_owner_e     push_owner_i,
    input  logic            pop_i,
    output ibus_owner_e     head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o
);

    logic [MaxOutstanding-1:0] mem_r;
    logic [PtrW-1:0]           wr_ptr_r;
    logic [PtrW-1:0]           rd_ptr_r;
    logic [CntW-1:0]           count_r;
    logic                      full_s;
    logic                      push_en_s;
    logic                      pop_en_s;

    // Advance a pointer, wrapping at the configured depth.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(MaxOutstanding - 32'd1)) begin
            return {PtrW{1'b0}};
        end else begin
            return ptr + PtrW'(1'b1);
        end
    endfunction

    assign full_s    = (count_r == CntW'(MaxOutstanding));
    // Overflow and underflow are refused locally so the queue never corrupts.
    assign push_en_s = push_i & ~full_s;
    assign pop_en_s  = pop_i & (count_r != {CntW{1'b0}});

    // Owner storage written at the tail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_r <= {MaxOutstanding{1'b0}};
        end else if (push_en_s) begin
            mem_r[wr_ptr_r] <= 1'(push_owner_i);
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CntW'(1'b1);
                2'b01:   count_r <= count_r - CntW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_o  = ibus_owner_e'(mem_r[rd_ptr_r]);
    assign count_o = count_r;
    assign full_o  = full_s;

endmodule

// File: rtl/cve2_instr_bus_arbiter.sv
// Two-requester instruction-bus arbiter (fetch F, auxiliary A) with zero-latency
// forwarding, owner hold while ungranted, and in-order response routing.
// CVE2_IBUS_ARB_RR_EN   : round-robin between F and A (default: F over A).
// CVE2_IBUS_ARB_ASSERT_EN: instantiate the protocol checker.
module cve2_instr_bus_arbiter
    import cve2_ibus_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 32'd2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    output logic        f_err_o,
    input  logic        a_req_i,
    input  logic [31:0] a_addr_i,
    output logic        a_gnt_o,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 32'd1);

    ibus_arb_state_e state_r;
    ibus_arb_state_e state_next_s;
    ibus_owner_e     owner_s;
    ibus_owner_e     head_s;
    logic            owner_req_s;
    logic            full_s;
    logic [CntW-1:0] count_s;
    logic            cnt_nz_s;
    logic            push_s;
    logic            pop_s;

`ifdef CVE2_IBUS_ARB_RR_EN
    ibus_owner_e     last_owner_r;

    // Remember who was granted last so a tie goes to the other requester.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_r <= OWNER_F;
        end else if (push_s) begin
            last_owner_r <= owner_s;
        end
    end
`endif

    // Owner selection: frozen in HOLD states, arbitrated in ARB.
    always_comb begin
        owner_s = OWNER_F;
        case (state_r)
            HOLD_F: owner_s = OWNER_F;
            HOLD_A: owner_s = OWNER_A;
            ARB: begin
`ifdef CVE2_IBUS_ARB_RR_EN
                if (f_req_i && a_req_i) begin
                    owner_s = (last_owner_r == OWNER_F) ? OWNER_A : OWNER_F;
                end else if (a_req_i) begin
                    owner_s = OWNER_A;
                end else begin
                    owner_s = OWNER_F;
                end
`else
                if (f_req_i) begin
                    owner_s = OWNER_F;
                end else if (a_req_i) begin
                    owner_s = OWNER_A;
                end else begin
                    owner_s = OWNER_F;
                end
`endif
            end
            default: owner_s = OWNER_F;
        endcase
    end

    assign owner_req_s  = (owner_s == OWNER_A) ? a_req_i : f_req_i;
    // Full blocks the request outright; a same-cycle rvalid does not reopen it.
    assign instr_req_o  = owner_req_s & ~full_s;
    assign instr_addr_o = (owner_s == OWNER_A) ? a_addr_i : f_addr_i;
    assign push_s       = instr_req_o & instr_gnt_i;
    assign f_gnt_o      = push_s & (owner_s == OWNER_F);
    assign a_gnt_o      = push_s & (owner_s == OWNER_A);

    // Hold the owner while its request waits for a grant so the address is stable.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB: begin
                if (instr_req_o && !instr_gnt_i) begin
                    state_next_s = (owner_s == OWNER_A) ? HOLD_A : HOLD_F;
                end else begin
                    state_next_s = ARB;
                end
            end
            HOLD_F: begin
                if (instr_gnt_i || !f_req_i) begin
                    state_next_s = ARB;
                end else begin
                    state_next_s = HOLD_F;
                end
            end
            HOLD_A: begin
                if (instr_gnt_i || !a_req_i) begin
                    state_next_s = ARB;
                end else begin
                    state_next_s = HOLD_A;
                end
            end
            default: state_next_s = ARB;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ARB;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Responses with nothing outstanding are dropped without popping.
    assign cnt_nz_s = (count_s != {CntW{1'b0}});
    assign pop_s    = instr_rvalid_i & cnt_nz_s;

    cve2_ibus_owner_fifo #(
        .MaxOutstanding (MaxOutstanding)
    ) u_owner_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push_s),
        .push_owner_i (owner_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .full_o       (full_s)
    );

    assign f_rvalid_o = pop_s & (head_s == OWNER_F);
    assign a_rvalid_o = pop_s & (head_s == OWNER_A);
    assign f_rdata_o  = instr_rdata_i;
    assign a_rdata_o  = instr_rdata_i;
    assign f_err_o    = instr_err_i;
    assign a_err_o    = instr_err_i;
    assign busy_o     = cnt_nz_s | instr_req_o;

`ifdef CVE2_IBUS_ARB_ASSERT_EN
    cve2_ibus_arb_chk #(
        .MaxOutstanding (MaxOutstanding)
    ) u_chk (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .state_i        (state_r),
        .f_req_i        (f_req_i),
        .a_req_i        (a_req_i),
        .instr_rvalid_i (instr_rvalid_i),
        .queue_empty_i  (~cnt_nz_s)
    );
`endif

endmodule

// File: tb/tb_cve2_instr_bus_arbiter.sv
// Directed self-checking bench for cve2_instr_bus_arbiter. A second instance
// with a deeper owner queue covers three back-to-back outstanding requests.
module tb_cve2_instr_bus_arbiter;
    import cve2_ibus_arb_pkg::*;

`ifdef CVE2_IBUS_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        f_req_i, a_req_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] f_addr_i, a_addr_i, instr_rdata_i;

    logic        f_gnt_o, f_rvalid_o, f_err_o, a_gnt_o, a_rvalid_o, a_err_o, instr_req_o, busy_o;
    logic [31:0] f_rdata_o, a_rdata_o, instr_addr_o;
    logic        f_gnt4, f_rvalid4, f_err4, a_gnt4, a_rvalid4, a_err4, instr_req4, busy4;
    logic [31:0] f_rdata4, a_rdata4, instr_addr4;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk_i = ~clk_i;

    cve2_instr_bus_arbiter #(.MaxOutstanding(32'd2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
        .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
        .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o)
    );

    cve2_instr_bus_arbiter #(.MaxOutstanding(32'd4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt4), .f_rvalid_o(f_rvalid4),
        .f_rdata_o(f_rdata4), .f_err_o(f_err4),
        .a_req_i(a_req_i), .a_addr_i(a_addr_i), .a_gnt_o(a_gnt4), .a_rvalid_o(a_rvalid4),
        .a_rdata_o(a_rdata4), .a_err_o(a_err4),
        .instr_req_o(instr_req4), .instr_addr_o(instr_addr4), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        f_req_i        = 1'b0;
        a_req_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_err_i    = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        logic h_a;
        logic exp_a;

        idle_inputs();
        f_addr_i      = 32'h0;
        a_addr_i      = 32'h0;
        rst_i         = 1'b1;
        instr_rdata_i = 32'hDEADBEEF;
        instr_err_i   = 1'b1;
        next_cycle();
        next_cycle();

        // Reset values and broadcast data path
        @(negedge clk_i);
        check_eq("rst_req",      32'(instr_req_o), 32'd0);
        check_eq("rst_f_gnt",    32'(f_gnt_o), 32'd0);
        check_eq("rst_a_gnt",    32'(a_gnt_o), 32'd0);
        check_eq("rst_f_rvalid", 32'(f_rvalid_o), 32'd0);
        check_eq("rst_a_rvalid", 32'(a_rvalid_o), 32'd0);
        check_eq("rst_busy",     32'(busy_o), 32'd0);
        check_eq("rst_f_rdata",  f_rdata_o, 32'hDEADBEEF);
        check_eq("rst_a_err",    32'(a_err_o), 32'd1);
        check_eq("rst_state",    32'(dut.state_r), 32'(ARB));
        check_eq("rst_count",    32'(dut.count_s), 32'd0);
        next_cycle();
        rst_i       = 1'b0;
        instr_err_i = 1'b0;

        // T1: F only, gnt always, rvalid one cycle after each grant
        for (int i = 0; i < 4; i++) begin
            f_req_i        = (i < 3);
            f_addr_i       = 32'h80 + 32'(4 * i);
            instr_gnt_i    = (i < 3);
            instr_rvalid_i = (i > 0);
            instr_rdata_i  = 32'h1000 + 32'(i);
            @(negedge clk_i);
            if (i < 3) begin
                check_eq("t1_addr",  instr_addr_o, 32'h80 + 32'(4 * i));
                check_eq("t1_f_gnt", 32'(f_gnt_o), 32'd1);
            end
            if (i > 0) begin
                check_eq("t1_f_rvalid", 32'(f_rvalid_o), 32'd1);
                check_eq("t1_f_rdata",  f_rdata_o, 32'h1000 + 32'(i));
                check_eq("t1_a_rvalid", 32'(a_rvalid_o), 32'd0);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk_i);
        check_eq("t1_count", 32'(dut.count_s), 32'd0);
        check_eq("t1_busy",  32'(busy_o), 32'd0);
        next_cycle();

        // T2: both request, gnt low for 3 cycles; owner must hold its address
        h_a      = RrEn;   // last grant was F, so round-robin favours A
        f_req_i  = 1'b1;
        a_req_i  = 1'b1;
        f_addr_i = 32'h100;
        a_addr_i = 32'h200;
        for (int c = 0; c < 4; c++) begin
            instr_gnt_i = (c == 3);
            @(negedge clk_i);
            check_eq("t2_addr", instr_addr_o, h_a ? 32'h200 : 32'h100);
            check_eq("t2_other_gnt", 32'(h_a ? f_gnt_o : a_gnt_o), 32'd0);
            check_eq("t2_held_gnt", 32'(h_a ? a_gnt_o : f_gnt_o), (c == 3) ? 32'd1 : 32'd0);
            if (c > 0) begin
                check_eq("t2_state", 32'(dut.state_r), h_a ? 32'(HOLD_A) : 32'(HOLD_F));
            end
            next_cycle();
        end
        if (h_a) a_req_i = 1'b0; else f_req_i = 1'b0;
        instr_gnt_i = 1'b1;
        @(negedge clk_i);
        check_eq("t2_addr_other", instr_addr_o, h_a ? 32'h100 : 32'h200);
        check_eq("t2_other_gnt2", 32'(h_a ? f_gnt_o : a_gnt_o), 32'd1);
        check_eq("t2_state_arb",  32'(dut.state_r), 32'(ARB));
        next_cycle();
        idle_inputs();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'h55;
        @(negedge clk_i);
        check_eq("t2_rv1_held",  32'(h_a ? a_rvalid_o : f_rvalid_o), 32'd1);
        check_eq("t2_rv1_other", 32'(h_a ? f_rvalid_o : a_rvalid_o), 32'd0);
        next_cycle();
        instr_rdata_i = 32'h66;
        @(negedge clk_i);
        check_eq("t2_rv2_other", 32'(h_a ? f_rvalid_o : a_rvalid_o), 32'd1);
        check_eq("t2_rv2_held",  32'(h_a ? a_rvalid_o : f_rvalid_o), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        check_eq("t2_count", 32'(dut.count_s), 32'd0);
        next_cycle();

        // T3: full at two outstanding; rvalid does not reopen req in its own cycle
        f_req_i     = 1'b1;
        instr_gnt_i = 1'b1;
        f_addr_i    = 32'h300;
        @(negedge clk_i);
        check_eq("t3_req0", 32'(instr_req_o), 32'd1);
        next_cycle();
        f_addr_i = 32'h304;
        @(negedge clk_i);
        check_eq("t3_req1", 32'(instr_req_o), 32'd1);
        next_cycle();
        f_addr_i = 32'h308;
        @(negedge clk_i);
        check_eq("t3_full_req",   32'(instr_req_o), 32'd0);
        check_eq("t3_full_busy",  32'(busy_o), 32'd1);
        check_eq("t3_full_gnt",   32'(f_gnt_o), 32'd0);
        check_eq("t3_full_count", 32'(dut.count_s), 32'd2);
        next_cycle();
        instr_rvalid_i = 1'b1;
        @(negedge clk_i);
        check_eq("t3_rv_req",    32'(instr_req_o), 32'd0);
        check_eq("t3_rv_rvalid", 32'(f_rvalid_o), 32'd1);
        next_cycle();
        instr_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("t3_reopen_req",   32'(instr_req_o), 32'd1);
        check_eq("t3_reopen_gnt",   32'(f_gnt_o), 32'd1);
        check_eq("t3_reopen_addr",  instr_addr_o, 32'h308);
        check_eq("t3_reopen_count", 32'(dut.count_s), 32'd1);
        next_cycle();
        idle_inputs();
        instr_rvalid_i = 1'b1;
        next_cycle();
        next_cycle();
        instr_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("t3_drain_count", 32'(dut.count_s), 32'd0);
        next_cycle();

        // T4: F, A, F back-to-back on the deep instance, rvalids three cycles later
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
            f_req_i        = (c == 0) || (c == 2);
            a_req_i        = (c == 1);
            f_addr_i       = 32'h1000 + 32'(c);
            a_addr_i       = 32'h2000 + 32'(c);
            instr_gnt_i    = (c < 3);
            instr_rvalid_i = (c >= 3);
            instr_rdata_i  = 32'hA0 + 32'(c);
            @(negedge clk_i);
            if (c < 3) begin
                check_eq("t4_f_gnt", 32'(f_gnt4), (c == 1) ? 32'd0 : 32'd1);
                check_eq("t4_a_gnt", 32'(a_gnt4), (c == 1) ? 32'd1 : 32'd0);
                check_eq("t4_addr",  instr_addr4, (c == 1) ? 32'h2001 : 32'h1000 + 32'(c));
            end else begin
                check_eq("t4_f_rvalid", 32'(f_rvalid4), (c == 4) ? 32'd0 : 32'd1);
                check_eq("t4_a_rvalid", 32'(a_rvalid4), (c == 4) ? 32'd1 : 32'd0);
                check_eq("t4_rdata",    (c == 4) ? a_rdata4 : f_rdata4, 32'hA0 + 32'(c));
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk_i);
        check_eq("t4_busy", 32'(busy4), 32'd0);
        next_cycle();

        // T5: one A grant, then both requesting continuously with gnt=1
        pulse_reset();
        a_req_i     = 1'b1;
        a_addr_i    = 32'h400;
        instr_gnt_i = 1'b1;
        @(negedge clk_i);
        check_eq("t5_a_first", 32'(a_gnt_o), 32'd1);
        next_cycle();
        f_req_i        = 1'b1;
        f_addr_i       = 32'h500;
        a_addr_i       = 32'h600;
        instr_rvalid_i = 1'b1;
        for (int c = 1; c < 5; c++) begin
            exp_a = RrEn && ((c % 2) == 0);
            @(negedge clk_i);
            check_eq("t5_f_gnt", 32'(f_gnt_o), exp_a ? 32'd0 : 32'd1);
            check_eq("t5_a_gnt", 32'(a_gnt_o), exp_a ? 32'd1 : 32'd0);
            check_eq("t5_addr",  instr_addr_o, exp_a ? 32'h600 : 32'h500);
            next_cycle();
        end
        f_req_i     = 1'b0;
        a_req_i     = 1'b0;
        instr_gnt_i = 1'b0;
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        check_eq("t5_count", 32'(dut.count_s), 32'd0);
        next_cycle();

        // T6: orphan rvalid, then reset with two outstanding
        instr_rvalid_i = 1'b1;
        @(negedge clk_i);
        check_eq("t6_orphan_f", 32'(f_rvalid_o), 32'd0);
        check_eq("t6_orphan_a", 32'(a_rvalid_o), 32'd0);
        next_cycle();
        instr_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("t6_orphan_count", 32'(dut.count_s), 32'd0);
        f_req_i     = 1'b1;
        f_addr_i    = 32'h700;
        instr_gnt_i = 1'b1;
        next_cycle();
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        check_eq("t6_pre_rst_count", 32'(dut.count_s), 32'd2);
        rst_i = 1'b1;
        next_cycle();
        rst_i          = 1'b0;
        instr_rvalid_i = 1'b1;
        @(negedge clk_i);
        check_eq("t6_rst_state",  32'(dut.state_r), 32'(ARB));
        check_eq("t6_rst_count",  32'(dut.count_s), 32'd0);
        check_eq("t6_post_rv_f",  32'(f_rvalid_o), 32'd0);
        check_eq("t6_post_rv_a",  32'(a_rvalid_o), 32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        check_eq("t6_final_count", 32'(dut.count_s), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
